// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch (IF) and data (DM) requesters.
// Optional round-robin tie-break when MEM_ARB_RR_EN is defined; otherwise DM always wins a tie.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e      state_q;
    logic        owner_q;
    logic        last_grant_q;
    logic [7:0]  cnt_q;
    logic        tie_dm;
    logic        grant_dm;
    logic        expired;
    logic [31:0] resp_data;
`ifdef MEM_ARB_RR_EN
    assign tie_dm = ~last_grant_q;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
    assign tie_dm = 1'b1;
`endif
    assign grant_dm  = dm_req_i & (~if_req_i | tie_dm);
    assign expired   = cnt_q >= 8'(TIMEOUT_CYCLES - 1);
    assign resp_data = mem_ack_i ? mem_rdata_i : '0;
    // Grant in IDLE, hold the memory request in BUSY until ack or timeout, pulse ready in DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            if_rdata_o   <= '0;
            dm_rdata_o   <= '0;
            if_ready_o   <= 1'b0;
            dm_ready_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (if_req_i | dm_req_i) begin
                    owner_q     <= grant_dm;
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= grant_dm & dm_we_i;
                    mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
                    mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
                    cnt_q       <= '0;
                    state_q     <= BUSY;
                end
                BUSY: if (mem_ack_i | expired) begin
                    mem_req_o  <= 1'b0;
                    if (owner_q) dm_rdata_o <= resp_data;
                    else if_rdata_o <= resp_data;
                    dm_ready_o <= owner_q;
                    if_ready_o <= ~owner_q;
                    bus_err_o  <= ~mem_ack_i;
                    state_q    <= DONE;
                end else begin
                    cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
                default: begin
                    if_ready_o   <= 1'b0;
                    dm_ready_o   <= 1'b0;
                    bus_err_o    <= 1'b0;
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven bench with a completion scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        bus_err_o;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        dm;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_data;
        int          delay;
        logic        noise;
        logic        exp_dm;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int          passed = 0;
    int          total = 0;
    logic [31:0] hold_if = '0;
    logic [31:0] hold_dm = '0;
    int          cur_delay = 0;
    logic [31:0] cur_data = '0;
    logic        noise = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Memory model: acks cur_delay cycles after mem_req first appears; optional stray acks while idle.
    initial begin
        int mcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                mem_ack_i   = (mcnt == cur_delay);
                mem_rdata_i = (mcnt == cur_delay) ? cur_data : (32'hBAD0_0000 | 32'(mcnt));
                mcnt++;
            end else begin
                mem_ack_i   = noise;
                mem_rdata_i = 32'h5A5A_5A5A;
                mcnt        = 0;
            end
        end
    end

    // Scoreboard monitor: checks the memory request against the oldest pending entry and pops on ready.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (mem_req_o && sb.size() > 0) begin
                check("mem_addr", mem_addr_o, sb[0].addr);
                check("mem_we", mem_we_o, sb[0].we);
                check("mem_wdata", mem_wdata_o, sb[0].wdata);
            end
            if (if_ready_o || dm_ready_o) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_ready: if_ready=%b dm_ready=%b, required none", if_ready_o, dm_ready_o);
                end else begin
                    e = sb.pop_front();
                    check("dm_ready", dm_ready_o, e.dm);
                    check("if_ready", if_ready_o, !e.dm);
                    check("rdata", e.dm ? dm_rdata_o : if_rdata_o, e.rdata);
                    check("bus_err", bus_err_o, e.err);
                    check("mem_req_at_ready", mem_req_o, 0);
                    check("ready_cycle", cyc, e.cyc);
                    if (e.dm) hold_dm = e.rdata;
                    else hold_if = e.rdata;
                end
            end
        end
    end

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() > 0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain_timeout: %0d pending after %0d cycles, required 0", sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic idle_checks();
        check("idle_if_ready", if_ready_o, 0);
        check("idle_dm_ready", dm_ready_o, 0);
        check("hold_if_rdata", if_rdata_o, hold_if);
        check("hold_dm_rdata", dm_rdata_o, hold_dm);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        if (v.noise) begin
            noise = 1'b1;
            @(negedge clk); #1;
        end
        cur_delay = v.delay;
        cur_data  = v.mem_data;
        e.dm      = v.exp_dm;
        e.addr    = v.exp_dm ? v.dm_addr : v.if_addr;
        e.we      = v.exp_dm & v.dm_we;
        e.wdata   = v.exp_dm ? v.dm_wdata : '0;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        e.cyc     = cyc + (v.exp_err ? TO + 1 : v.delay + 2);
        sb.push_back(e);
        if_req_i   = v.if_req;
        if_addr_i  = v.if_addr;
        dm_req_i   = v.dm_req;
        dm_we_i    = v.dm_we;
        dm_addr_i  = v.dm_addr;
        dm_wdata_i = v.dm_wdata;
        wait_drain(40);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        noise    = 1'b0;
        @(negedge clk); #1;
        idle_checks();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   c;
        //          if dm we  if_addr       dm_addr       dm_wdata      mem_data      dly  nz dm err rdata
        vecs[0] = '{1, 0, 0, 32'h0000_0100, 32'h0,        32'h0,        32'hDEADBEEF, 0,   0, 0, 0, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 1, 32'h0,         32'h0000_2000, 32'h12345678, 32'hCAFEF00D, 3,   0, 1, 0, 32'hCAFEF00D};
        vecs[2] = '{0, 1, 0, 32'h0,         32'h0000_3000, 32'h0,        32'h13579BDF, 255, 0, 1, 1, 32'h0};
        vecs[3] = '{0, 1, 0, 32'h0,         32'h0000_3004, 32'h0,        32'h0BADF00D, 7,   0, 1, 0, 32'h0BADF00D};
        vecs[4] = '{1, 0, 0, 32'h0000_0104, 32'hFFFF_0000, 32'hFFFFFFFF, 32'h11112222, 6,   1, 0, 0, 32'h11112222};
        vecs[5] = '{1, 0, 0, 32'h0000_0108, 32'h0,        32'h0,        32'h2468ACE0, 255, 0, 0, 1, 32'h0};
        vecs[6] = '{0, 1, 0, 32'h0,         32'h0000_0040, 32'h0,        32'h55AA55AA, 1,   0, 1, 0, 32'h55AA55AA};

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_if_ready", if_ready_o, 0);
        check("rst_dm_ready", dm_ready_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_dm_rdata", dm_rdata_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset asserted in T2 of a fetch that never gets acked.
        cur_delay = 255;
        if_addr_i = 32'h0000_0700;
        if_req_i  = 1'b1;
        @(negedge clk); #1;
        check("rst_t1_mem_req", mem_req_o, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_mem_req", mem_req_o, 0);
        check("async_mem_addr", mem_addr_o, 0);
        check("async_if_ready", if_ready_o, 0);
        check("async_dm_rdata", dm_rdata_o, 0);
        hold_if = '0;
        hold_dm = '0;
        repeat (2) @(negedge clk);
        #1;
        check("in_rst_mem_req", mem_req_o, 0);
        cur_delay = 0;
        cur_data  = 32'h9999_0000;
        e = '{1'b0, 32'h0000_0700, 1'b0, 32'h0, 32'h9999_0000, 1'b0, cyc + 2};
        sb.push_back(e);
        rst_n = 1'b1;
        wait_drain(20);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        idle_checks();

        // Both requesters held for four back-to-back accesses.
        cur_delay = 0;
        cur_data  = 32'h7777_8888;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            e.dm = (k % 2 == 0);
`else
            e.dm = 1'b1;
`endif
            e.addr  = e.dm ? 32'h0000_0500 : 32'h0000_0600;
            e.we    = 1'b0;
            e.wdata = '0;
            e.rdata = 32'h7777_8888;
            e.err   = 1'b0;
            e.cyc   = c + 2 + 3 * k;
            sb.push_back(e);
        end
        if_addr_i = 32'h0000_0600;
        dm_addr_i = 32'h0000_0500;
        dm_we_i   = 1'b0;
        if_req_i  = 1'b1;
        dm_req_i  = 1'b1;
        wait_drain(30);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        @(negedge clk); #1;
        idle_checks();
        @(negedge clk); #1;
        check("no_extra_grant", mem_req_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its data-memory port. Grants one requester at a time and holds the memory-side request stable until acknowledge. Returns read data with a one-cycle `ready` pulse and enforces a bounded wait via timeout. Sits between the fetch/memory pipeline stages and the shared memory; requester `ready` lows drive the pipeline stall logic.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles in BUSY without `mem_ack` before forced completion; 1..255.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs immediately.
- `if_req` in 1: fetch request; held with `if_addr` until `if_ready`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetch data, valid while `if_ready`=1.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `dm_req` in 1: data request; held with `dm_we`/`dm_addr`/`dm_wdata` until `dm_ready`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in 32, `dm_wdata` in 32: data address / store data.
- `dm_rdata` out 32: load data, valid while `dm_ready`=1.
- `dm_ready` out 1: one-cycle completion pulse for data.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: memory request, registered.
- `mem_rdata` in 32, `mem_ack` in 1: memory response; `mem_rdata` valid when `mem_ack`=1.
- `bus_err` out 1: one-cycle pulse alongside `*_ready` when completion was by timeout.

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; all outputs 0; `last_grant`=IF; timeout counter 0.
- IDLE: no request -> stay. Only one pending -> grant it. Both pending -> priority rule (Configuration). On grant: latch `owner`, drive `mem_req`=1, `mem_addr`, `mem_we` (0 for fetch), `mem_wdata` (0 for fetch) from next cycle; counter cleared; -> BUSY.
- BUSY: all `mem_*` outputs held constant. `mem_ack`=1 -> capture `mem_rdata` into owner's rdata register, `mem_req`=0, -> DONE. Counter reaches `TIMEOUT_CYCLES` without ack -> rdata = 0, set err flag, `mem_req`=0, -> DONE.
- DONE: owner's `ready`=1 one cycle, `bus_err`=err flag; non-owner `ready`=0; `last_grant`=owner; no grant this cycle; -> IDLE.
- Store completion: `dm_ready` pulses, `dm_rdata`=`mem_rdata` as captured (don't-care for pipeline).
- `if_rdata`/`dm_rdata` hold last captured value outside ready pulses.
- `mem_ack` outside BUSY ignored. Requester dropping `req` mid-transaction is illegal; arbiter completes the transaction regardless.
- Counter 8 bits, saturating; never wraps.

## Timing
- Grant cycle T0 (IDLE, req sampled high); `mem_req`=1 from T1.
- `mem_ack` high in cycle Tn (n>=1) -> `ready` pulse in Tn+1 -> IDLE in Tn+2.
- Minimum 3 cycles per access (T0 grant, T1 ack, T2 ready); back-to-back throughput 1 access / 3 cycles.
- Timeout: `mem_ack` low in T1..T(TIMEOUT_CYCLES) -> `ready`+`bus_err` in T(TIMEOUT_CYCLES+1).
- Simultaneous ack and timeout in the same cycle: ack wins, `bus_err`=0.
- `reset` low at any time, including BUSY: `mem_req` and all `ready` drop asynchronously; transaction discarded; IDLE after release; first grant no earlier than first rising edge with `reset`=1.

## Configuration
- `MEM_ARB_RR_EN` defined: tie in IDLE -> grant the requester not equal to `last_grant` (round-robin); first tie after reset goes to DM.
- Undefined: tie -> DM always wins (fixed priority); `last_grant` still updated but unused for arbitration.

## Test plan
- Single fetch, `if_addr`=0x100, memory acks 1 cycle after `mem_req` with 0xDEADBEEF -> `mem_req` T1, `if_ready`=1 and `if_rdata`=0xDEADBEEF in T2, `dm_ready`=0.
- Store `dm_addr`=0x2000, `dm_wdata`=0x12345678, ack after 4 cycles -> `mem_we`=1, `mem_addr`/`mem_wdata` constant T1..T4, `dm_ready` T5.
- `if_req` and `dm_req` both held high for 4 accesses -> fixed priority: DM granted 4x, `if_ready` never; with `MEM_ARB_RR_EN`: grant order DM, IF, DM, IF.
- `TIMEOUT_CYCLES`=8, load with no ack -> `dm_ready`=1, `bus_err`=1, `dm_rdata`=0 in T9; `mem_req` low T9.
- Ack arriving exactly in T8 with `TIMEOUT_CYCLES`=8 -> normal completion T9, `bus_err`=0.
- `reset` low in T2 of a BUSY fetch -> `mem_req`=0 immediately, no `if_ready`; after release with `if_req` held, fresh grant and normal completion.
